// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator: decodes one instruction per cycle into a
// main result register backed by a skid register, and counts illegal opcodes it delivers.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  res_t        dec;
  res_t        main_q, skid_q;
  logic        main_valid_q, skid_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] imm32;
  logic        in_acc, out_xfer, load_main;

  // Every immediate is built as a 32-bit value whose bit 31 is the sign, then widened.
  always_comb begin
    imm32       = '0;
    dec         = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    unique case (in_instr[6:0])
      7'b0010011: begin
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
          dec.fmt = FMT_SHAMT;
          imm32   = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        end else begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      7'b0110011: dec.fmt = FMT_R;
      default:    dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    dec.tag = in_tag;
  end

  // Handshake: a beat moves when valid and ready are both high at a rising edge; a producer
  // holds valid and payload until accepted, and ready never depends on the same-cycle valid.
  assign in_ready  = ~skid_valid_q;
  assign in_acc    = in_valid & in_ready;
  assign out_xfer  = main_valid_q & out_ready;
  assign load_main = ~main_valid_q | out_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (load_main) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_acc) begin
        main_q       <= dec;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (in_acc) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_xfer && main_q.illegal && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN 32, XLEN 64, 2-bit counter) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;
  logic        rdyc2, vldc2, illc2;
  logic [31:0] immc2, tagc2;
  logic [2:0]  fmtc2;
  logic [1:0]  cntc2;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32), .cnt_clr(cnt_clr),
    .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64), .cnt_clr(cnt_clr),
    .illegal_cnt(cnt64));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) uc2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyc2), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(vldc2), .out_ready(out_ready), .out_imm(immc2),
    .out_fmt(fmtc2), .out_illegal(illc2), .out_tag(tagc2), .cnt_clr(cnt_clr),
    .illegal_cnt(cntc2));

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference decoder, straight from the format table
  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h13:               return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd6 : 3'd1;
      7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      7'h33:               return 3'd0;
      default:             return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen);
    logic signed [63:0] v;
    case (ref_fmt(i))
      3'd1:    v = 64'($signed(i[31:20]));
      3'd2:    v = 64'($signed({i[31:25], i[11:7]}));
      3'd3:    v = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4:    v = 64'($signed({i[31:12], 12'b0}));
      3'd5:    v = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd6:    v = (xlen == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
      default: v = '0;
    endcase
    return (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  // model: an ordered queue of at most two pending results; {tag, instr} per entry
  logic [63:0] exp_q[$];
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt2 = 0;
  logic m_acc, m_xfer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else begin
      m_acc  = in_valid && (exp_q.size() < 2);
      m_xfer = (exp_q.size() > 0) && out_ready;
      if (cnt_clr) begin
        m_cnt16 = 0;
        m_cnt2  = 0;
      end else if (m_xfer && ref_fmt(exp_q[0][31:0]) == 3'd7) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (m_xfer) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({in_tag, in_instr});
    end
  end

  task automatic cmp_dut(input string nm, input int xlen, input logic rdy, input logic vld,
                         input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                         input logic [31:0] tag, input logic [15:0] cnt, input logic [15:0] ecnt);
    logic [31:0] ins;
    check({nm, ".in_ready"}, 64'(rdy), 64'(exp_q.size() < 2));
    check({nm, ".out_valid"}, 64'(vld), 64'(exp_q.size() > 0));
    check({nm, ".cnt"}, 64'(cnt), 64'(ecnt));
    if (exp_q.size() > 0) begin
      ins = exp_q[0][31:0];
      check({nm, ".imm"}, imm, ref_imm(ins, xlen));
      check({nm, ".fmt"}, 64'(fmt), 64'(ref_fmt(ins)));
      check({nm, ".illegal"}, 64'(ill), 64'(ref_fmt(ins) == 3'd7));
      check({nm, ".tag"}, 64'(tag), 64'(exp_q[0][63:32]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp_dut("x32", 32, rdy32, vld32, {32'b0, imm32}, fmt32, ill32, tag32, cnt32, 16'(m_cnt16));
      cmp_dut("x64", 64, rdy64, vld64, imm64, fmt64, ill64, tag64, cnt64, 16'(m_cnt16));
      cmp_dut("c2", 32, rdyc2, vldc2, {32'b0, immc2}, fmtc2, illc2, tagc2, {14'b0, cntc2},
              16'(m_cnt2));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] tg);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
  endtask

  task automatic dir(input string nm, input logic [31:0] ins, input int xlen,
                     input logic [63:0] eimm, input logic [2:0] efmt);
    out_ready = 1'b1;
    drive(ins, ins ^ 32'h5A5A_0000);
    step();
    in_valid = 1'b0;
    if (xlen == 64) begin
      check({nm, ".vld"}, 64'(vld64), 64'd1);
      check({nm, ".imm"}, imm64, eimm);
      check({nm, ".fmt"}, 64'(fmt64), 64'(efmt));
    end else begin
      check({nm, ".vld"}, 64'(vld32), 64'd1);
      check({nm, ".imm"}, {32'b0, imm32}, eimm);
      check({nm, ".fmt"}, 64'(fmt32), 64'(efmt));
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, ".vld"}, 64'(vld32), 64'd0);
    check({nm, ".imm"}, {32'b0, imm32}, 64'd0);
    check({nm, ".imm64"}, imm64, 64'd0);
    check({nm, ".fmt"}, 64'(fmt32), 64'd0);
    check({nm, ".ill"}, 64'(ill32), 64'd0);
    check({nm, ".tag"}, 64'(tag32), 64'd0);
    check({nm, ".rdy"}, 64'(rdy32), 64'd1);
    check({nm, ".cnt"}, 64'(cnt32), 64'd0);
    check({nm, ".cntc2"}, 64'(cntc2), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[10];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  int   acc_n;
  int   cyc;
  logic pend;
  logic took;

  initial begin
    #1;
    check_cleared("reset");
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // directed decode table
    dir("i_pos",   32'h0070_0013, 32, 64'h0000_0000_0000_0007, 3'd1);
    dir("i_neg",   32'hE070_0013, 32, 64'h0000_0000_FFFF_FE07, 3'd1);
    dir("s_neg",   32'hE070_0023, 32, 64'h0000_0000_FFFF_FE00, 3'd2);
    dir("b_two",   32'h0000_0163, 32, 64'h0000_0000_0000_0002, 3'd3);
    dir("b_2048",  32'h0000_00E3, 32, 64'h0000_0000_0000_0800, 3'd3);
    dir("b_min",   32'h8000_0063, 32, 64'h0000_0000_FFFF_F000, 3'd3);
    dir("r_zero",  32'h0200_0033, 32, 64'h0, 3'd0);
    dir("u_lui",   32'h1234_52B7, 32, 64'h0000_0000_1234_5000, 3'd4);
    dir("u_sx64",  32'h8000_00B7, 64, 64'hFFFF_FFFF_8000_0000, 3'd4);
    dir("j_min",   32'h8000_00EF, 32, 64'h0000_0000_FFF0_0000, 3'd5);
    dir("sh_64",   32'h03F0_1013, 64, 64'd63, 3'd6);
    dir("sh_32",   32'h03F0_1013, 32, 64'd31, 3'd6);
    step();

    // backpressure: two accepts fill main and skid, the third waits
    out_ready = 1'b0;
    drive(32'h0070_0013, 32'd1);
    step();
    drive(32'h0080_0013, 32'd2);
    step();
    check("bp.rdy_drop", 64'(rdy32), 64'd0);
    drive(32'h0090_0013, 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp.stall_tag", 64'(tag32), 64'd1);
      check("bp.stall_imm", {32'b0, imm32}, 64'd7);
      check("bp.stall_rdy", 64'(rdy32), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp.tag2", 64'(tag32), 64'd2);
    check("bp.rdy_back", 64'(rdy32), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp.tag3", 64'(tag32), 64'd3);
    step();
    check("bp.drained", 64'(vld32), 64'd0);

    // illegal opcodes and counter saturation
    for (int k = 0; k < 5; k++) begin
      drive(32'hABCD_E07F ^ (k << 12), 32'h100 + k);
      step();
      check("ill.fmt", 64'(fmt32), 64'd7);
      check("ill.imm", {32'b0, imm32}, 64'd0);
      check("ill.flag", 64'(ill32), 64'd1);
    end
    drive(32'h0070_0013, 32'h200);
    step();
    in_valid = 1'b0;
    step();
    check("ill.cnt5", 64'(cnt32), 64'd5);
    check("ill.cnt_sat", 64'(cntc2), 64'd3);
    drive(32'h0000_007F, 32'h300);
    step();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr.cnt", 64'(cnt32), 64'd0);
    check("clr.cntc2", 64'(cntc2), 64'd0);

    // asynchronous reset with main and skid both full
    out_ready = 1'b0;
    drive(32'hFFF0_0013, 32'h400);
    step();
    drive(32'h0000_007F, 32'h401);
    step();
    in_valid = 1'b0;
    check("rst.full", 64'(rdy32), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst.async");
    step();
    rst_n = 1'b1;
    step();
    check("rst.rdy", 64'(rdy32), 64'd1);
    check("rst.vld", 64'(vld32), 64'd0);
    dir("rst.next", 32'hE070_0023, 32, 64'h0000_0000_FFFF_FE00, 3'd2);
    step();

    // random stream
    acc_n = 0;
    cyc   = 0;
    pend  = 1'b0;
    while (acc_n < 10000 && cyc < 80000) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(rand_instr(), $urandom);
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      #1;
      check("rand.rdy_indep", 64'(rdy32), 64'(exp_q.size() < 2));
      took = in_valid && (exp_q.size() < 2);
      step();
      if (took) begin
        acc_n++;
        pend = 1'b0;
      end
      cyc++;
    end
    if (acc_n < 10000) check("rand.budget", 64'(acc_n), 64'd10000);
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rand.empty", 64'(vld32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
